// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS multiply/divide path: op codes and FSM states.
package mips_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10
    } md_state_t;

    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mips_muldiv_unit_addsub.sv
// Adder/subtractor: o_sum = i_x + (i_sub ? ~i_y : i_y) + i_cin, with carry out.
// Combinational, no backpressure.
module muldiv_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    input  logic         i_sub,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    logic [W-1:0] w_y;

    assign w_y = i_sub ? ~i_y : i_y;
    assign {o_cout, o_sum} = {1'b0, i_x} + {1'b0, w_y} + {{W{1'b0}}, i_cin};

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative radix-2 mult/multu/div/divu unit with HI/LO registers; WIDTH+1 busy cycles, done pulse after.
// start/mthi/mtlo are ignored while busy. MULDIV_DIVZERO_EN: divide-by-zero skips CALC and pulses div0.
module mips_muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
`ifdef MULDIV_DIVZERO_EN
    output logic             div0,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t          r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_m;
    logic [1:0]         r_op;
    logic               r_neg_q, r_neg_r, r_done;
    logic [WIDTH-1:0]   r_hi, r_lo;

    logic [WIDTH-1:0]   w_upper, w_lower, w_abs_a, w_abs_b;
    logic [WIDTH:0]     w_hx, w_hy, w_hsum;
    logic               w_hsub, w_hcin, w_hcout;
    logic [WIDTH-1:0]   w_ly, w_lsum;
    logic               w_lcout, w_dz;

    assign w_upper = r_acc[2*WIDTH-1:WIDTH];
    assign w_lower = r_acc[WIDTH-1:0];

`ifdef MULDIV_DIVZERO_EN
    logic r_dz;
    assign w_dz = md_is_div(op) && (b == '0);
    assign div0 = r_done & r_dz;
`else
    assign w_dz = 1'b0;
`endif

    // u_hi: negates a at accept, runs the add/subtract step in CALC, negates the upper word in FIX.
    // u_lo: negates b at accept and the lower word in FIX; its carry marks lower==0 for the 64-bit negate.
    always_comb begin
        w_hx   = '0;
        w_hy   = {1'b0, a};
        w_hsub = 1'b1;
        w_hcin = 1'b1;
        case (r_state)
            MD_CALC: begin
                if (md_is_div(r_op)) begin
                    w_hx = {w_upper, w_lower[WIDTH-1]};
                    w_hy = {1'b0, r_m};
                end else begin
                    w_hx   = {1'b0, w_upper};
                    w_hy   = w_lower[0] ? {1'b0, r_m} : '0;
                    w_hsub = 1'b0;
                    w_hcin = 1'b0;
                end
            end
            MD_FIX: begin
                w_hy   = {1'b0, w_upper};
                w_hcin = md_is_div(r_op) ? 1'b1 : w_lcout;
            end
            default: ;
        endcase
    end

    assign w_ly = (r_state == MD_IDLE) ? b : w_lower;

    muldiv_addsub #(.W(WIDTH + 1)) u_hi (
        .i_x(w_hx), .i_y(w_hy), .i_sub(w_hsub), .i_cin(w_hcin), .o_sum(w_hsum), .o_cout(w_hcout)
    );

    muldiv_addsub #(.W(WIDTH)) u_lo (
        .i_x('0), .i_y(w_ly), .i_sub(1'b1), .i_cin(1'b1), .o_sum(w_lsum), .o_cout(w_lcout)
    );

    assign w_abs_a = (md_is_signed(op) && a[WIDTH-1]) ? w_hsum[WIDTH-1:0] : a;
    assign w_abs_b = (md_is_signed(op) && b[WIDTH-1]) ? w_lsum : b;

    always_ff @(posedge clk) begin
        if (reset) r_state <= MD_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            MD_IDLE: if (start) w_next = w_dz ? MD_FIX : MD_CALC;
            MD_CALC: if (r_cnt == '0) w_next = MD_FIX;
            MD_FIX:  w_next = MD_IDLE;
            default: w_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_m     <= '0;
            r_op    <= MD_MULT;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
`ifdef MULDIV_DIVZERO_EN
            r_dz    <= 1'b0;
`endif
        end else begin
            r_done <= (r_state == MD_FIX);
            case (r_state)
                MD_IDLE: begin
                    if (hi_we) r_hi <= wd;
                    if (lo_we) r_lo <= wd;
                    if (start) begin
                        r_op    <= op;
                        r_cnt   <= CNT_W'(WIDTH - 1);
                        r_neg_q <= md_is_signed(op) & (a[WIDTH-1] ^ b[WIDTH-1]) & ~w_dz;
                        r_neg_r <= md_is_signed(op) & a[WIDTH-1];
`ifdef MULDIV_DIVZERO_EN
                        r_dz    <= w_dz;
`endif
                        if (md_is_div(op)) begin
                            r_m   <= w_abs_b;
                            // a zero divisor goes straight to FIX with the result pre-formed
                            r_acc <= w_dz ? {w_abs_a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, w_abs_a};
                        end else begin
                            r_m   <= w_abs_a;
                            r_acc <= {{WIDTH{1'b0}}, w_abs_b};
                        end
                    end
                end
                MD_CALC: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                    if (md_is_div(r_op))
                        r_acc <= {w_hcout ? w_hsum[WIDTH-1:0] : w_hx[WIDTH-1:0],
                                  w_lower[WIDTH-2:0], w_hcout};
                    else
                        r_acc <= {w_hsum, w_lower[WIDTH-1:1]};
                end
                MD_FIX: begin
                    r_hi <= (md_is_div(r_op) ? r_neg_r : r_neg_q) ? w_hsum[WIDTH-1:0] : w_upper;
                    r_lo <= r_neg_q ? w_lsum : w_lower;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != MD_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Bench for mips_muldiv_unit: vector table, random ops against a 64-bit model, handshake/reset sequences.
module tb_mips_muldiv_unit;

`ifdef MULDIV_DIVZERO_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, hi_we, lo_we, busy, done;
    logic [1:0]  op;
    logic [31:0] a, b, wd, hi, lo;
`ifdef MULDIV_DIVZERO_EN
    logic        div0;
`endif

    always #5 clk = ~clk;

    mips_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wd(wd), .busy(busy), .done(done),
`ifdef MULDIV_DIVZERO_EN
        .div0(div0),
`endif
        .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy_cyc;
        bit          dz;
    } exp_t;

    exp_t sb_q[$];
    vec_t vt[15];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy;
        logic [63:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00:   r = 64'(sx * sy);
            2'b01:   r = {32'h0, x} * {32'h0, y};
            2'b10:   r = {32'(sx % sy), 32'(sx / sy)};
            default: r = {x % y, x / y};
        endcase
        return r;
    endfunction

    // mode 0: plain op; 1: start + mthi injected mid-busy; 2: mthi together with the accepted start
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int mode, input logic [31:0] hold);
        exp_t e;
        int   nb;
        bit   seen;
        e.hi       = ehi;
        e.lo       = elo;
        e.dz       = DZ_EN && o[1] && (y == 32'h0);
        e.busy_cyc = e.dz ? 1 : 33;
        sb_q.push_back(e);

        op = o; a = x; b = y; start = 1'b1;
        if (mode == 2) begin hi_we = 1'b1; wd = 32'h5555; end
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        if (mode == 2) check("mthi_with_start", 64'(hi), 64'h5555);

        nb = 0; seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (done) seen = 1;
            else begin
                if (busy) nb++;
                if (mode == 1 && nb == 6) check("mthi_busy_dropped", 64'(hi), 64'(hold));
                if (mode == 1 && nb == 5) begin
                    start = 1'b1; op = 2'b01; a = 32'h3; b = 32'h3; hi_we = 1'b1; wd = 32'h1234;
                end else begin
                    start = 1'b0; hi_we = 1'b0;
                end
                @(posedge clk); #1;
            end
        end
        start = 1'b0; hi_we = 1'b0;

        e = sb_q.pop_front();
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: got no done, expected done after %0d busy cycles", e.busy_cyc);
        end else begin
            check("busy_cycles", 64'(nb), 64'(e.busy_cyc));
            check("hi", 64'(hi), 64'(e.hi));
            check("lo", 64'(lo), 64'(e.lo));
            check("busy_at_done", 64'(busy), 64'h0);
`ifdef MULDIV_DIVZERO_EN
            check("div0", 64'(div0), 64'(e.dz));
`endif
            @(posedge clk); #1;
            check("done_one_cycle", 64'(done), 64'h0);
        end
    endtask

    initial begin
        logic [31:0] rx, ry;
        logic [1:0]  ro;
        logic [63:0] m;

        vt[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vt[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vt[2]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vt[3]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
        vt[4]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vt[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vt[6]  = '{2'b00, 32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6};
        vt[7]  = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vt[8]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vt[9]  = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        vt[10] = '{2'b10, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
        vt[11] = '{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, DZ_EN ? 32'hFFFFFFFF : 32'h00000001};
        vt[12] = '{2'b11, 32'h80000001, 32'h00000000, 32'h80000001, 32'hFFFFFFFF};
        vt[13] = '{2'b11, 32'h00000000, 32'h00000003, 32'h00000000, 32'h00000000};
        vt[14] = '{2'b00, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};

        reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; a = '0; b = '0; wd = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_done", 64'(done), 64'h0);
        check("reset_hi", 64'(hi), 64'h0);
        check("reset_lo", 64'(lo), 64'h0);

        hi_we = 1'b1; wd = 32'h1234;
        @(posedge clk); #1;
        hi_we = 1'b0;
        check("mthi_idle_hi", 64'(hi), 64'h1234);
        check("mthi_idle_lo", 64'(lo), 64'h0);
        hi_we = 1'b1; lo_we = 1'b1; wd = 32'hCAFE;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        check("mthi_mtlo_hi", 64'(hi), 64'hCAFE);
        check("mthi_mtlo_lo", 64'(lo), 64'hCAFE);

        run_op(2'b01, 32'd6, 32'd7, 32'h0, 32'd42, 1, 32'hCAFE);
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 2, 32'h0);

        for (int i = 0; i < 15; i++)
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, 0, 32'h0);

        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (ry == 32'h0) ry = 32'h1;
            m = model(ro, rx, ry);
            run_op(ro, rx, ry, m[63:32], m[31:0], 0, 32'h0);
        end

        op = 2'b01; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("midcalc_reset_busy", 64'(busy), 64'h0);
        check("midcalc_reset_done", 64'(done), 64'h0);
        check("midcalc_reset_hi", 64'(hi), 64'h0);
        check("midcalc_reset_lo", 64'(lo), 64'h0);
        @(posedge clk); #1;
        check("midcalc_reset_no_done", 64'(done), 64'h0);

        run_op(2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
